// File: rtl/video_write_buffer_v_if.sv
`default_nettype none
// ============================================================================
// Module : video_write_buffer_v_if
// Brief  : CPU-side write request and VRAM-side write port bundle for the
//          video write buffer.
// Rev    : 1.0  initial release
// ============================================================================
interface video_write_buffer_v_if #(
  parameter int ADDR_W = 3
) ();
  logic              videoflag;
  logic [15:0]       bus_vga_pos;
  logic [15:0]       bus_vga_char;
  logic              vram_ready;
  logic              err_clr;
  logic              vram_we;
  logic [15:0]       vram_addr;
  logic [15:0]       vram_data;
  logic [ADDR_W:0]   fifo_count;
  logic              overflow;
  logic              pos_err;

  // Buffer side
  modport slave (
    input  videoflag, bus_vga_pos, bus_vga_char, vram_ready, err_clr,
    output vram_we, vram_addr, vram_data, fifo_count, overflow, pos_err
  );

  // CPU / video-controller side
  modport master (
    output videoflag, bus_vga_pos, bus_vga_char, vram_ready, err_clr,
    input  vram_we, vram_addr, vram_data, fifo_count, overflow, pos_err
  );
endinterface
`default_nettype wire

// File: rtl/video_write_buffer_v.sv
`default_nettype none
// ============================================================================
// Module : video_write_buffer_v
// Brief  : FIFO between CPU character writes and the VGA character-memory
//          write port; drops off-screen positions and flags lost writes.
// Rev    : 1.0  initial release
// ============================================================================
module video_write_buffer_v #(
  parameter int ADDR_W  = 3,
  parameter int POS_MAX = 1199
) (
  input  wire logic             wire_clock,
  input  wire logic             wire_reset,
  video_write_buffer_v_if.slave bus
);

  localparam int              c_depth   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] c_full    = (ADDR_W + 1)'(c_depth);
  localparam logic [15:0]     c_pos_max = 16'(POS_MAX);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_flag_d;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_mem [c_depth];

  logic w_req;
  logic w_pos_bad;
  logic w_avail;
  logic w_load;
  logic w_push;
  logic w_ovf;

  // Only the rising edge of videoflag is a request, however long it is held.
  assign w_req     = bus.videoflag & ~r_flag_d;
  assign w_pos_bad = w_req && (bus.bus_vga_pos > c_pos_max);
  assign w_avail   = (r_count != '0) && bus.vram_ready;

  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign w_push = w_req && !w_pos_bad && ((r_count != c_full) || w_load);
  assign w_ovf  = w_req && !w_pos_bad && (r_count == c_full) && !w_load;

  always_ff @(posedge wire_clock or posedge wire_reset) begin
    if (wire_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_avail) begin
          w_load      = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_avail) begin
          w_load = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge wire_clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.bus_vga_pos, bus.bus_vga_char};
    end
  end

  always_ff @(posedge wire_clock or posedge wire_reset) begin
    if (wire_reset) begin
      r_flag_d       <= 1'b0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      bus.vram_we    <= 1'b0;
      bus.vram_addr  <= '0;
      bus.vram_data  <= '0;
      bus.overflow   <= 1'b0;
      bus.pos_err    <= 1'b0;
    end else begin
      r_flag_d    <= bus.videoflag;
      bus.vram_we <= w_load;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_load) begin
        r_rd_ptr                        <= r_rd_ptr + 1'b1;
        {bus.vram_addr, bus.vram_data}  <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + {{ADDR_W{1'b0}}, w_push} - {{ADDR_W{1'b0}}, w_load};
      // A new error in the clearing cycle keeps the flag set.
      bus.overflow <= (bus.overflow & ~bus.err_clr) | w_ovf;
      bus.pos_err  <= (bus.pos_err  & ~bus.err_clr) | w_pos_bad;
    end
  end

  assign bus.fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_video_write_buffer_v.sv
`default_nettype none
// ============================================================================
// Module : tb_video_write_buffer_v
// Brief  : Directed bench for video_write_buffer_v with a write scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_video_write_buffer_v;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  int   n_strobes;
  int   base;
  logic [31:0] exp_q[$];

  video_write_buffer_v_if #(.ADDR_W(3)) bus ();

  video_write_buffer_v #(
    .ADDR_W (3),
    .POS_MAX(1199)
  ) dut (
    .wire_clock(clk),
    .wire_reset(rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request followed by one idle cycle so each call is a fresh edge.
  task automatic req(input logic [15:0] pos, input logic [15:0] ch);
    bus.videoflag    = 1'b1;
    bus.bus_vga_pos  = pos;
    bus.bus_vga_char = ch;
    tick();
    bus.videoflag = 1'b0;
    tick();
  endtask

  // Every strobe is matched against the oldest expected write.
  always @(negedge clk) begin
    if (!rst && bus.vram_we) begin
      logic [31:0] e;
      n_strobes++;
      chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("vram_addr", 32'(bus.vram_addr), 32'(e[31:16]));
        chk("vram_data", 32'(bus.vram_data), 32'(e[15:0]));
      end
    end
  end

  initial begin
    n_pass = 0; n_total = 0; n_strobes = 0;
    rst = 1'b1;
    bus.videoflag = 1'b0; bus.bus_vga_pos = '0; bus.bus_vga_char = '0;
    bus.vram_ready = 1'b0; bus.err_clr = 1'b0;
    tick(); tick();
    chk("rst_we",    32'(bus.vram_we),    32'd0);
    chk("rst_addr",  32'(bus.vram_addr),  32'd0);
    chk("rst_data",  32'(bus.vram_data),  32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_ovf",   32'(bus.overflow),   32'd0);
    chk("rst_poserr",32'(bus.pos_err),    32'd0);
    rst = 1'b0;
    tick();

    // Single write, videoflag held for three cycles
    bus.vram_ready = 1'b1;
    bus.videoflag = 1'b1; bus.bus_vga_pos = 16'd5; bus.bus_vga_char = 16'h0241;
    exp_q.push_back({16'd5, 16'h0241});
    tick();
    chk("single_cnt_after_capture", 32'(bus.fifo_count), 32'd1);
    chk("single_we_at_capture",     32'(bus.vram_we),    32'd0);
    tick();
    chk("single_we",   32'(bus.vram_we),   32'd1);
    chk("single_addr", 32'(bus.vram_addr), 32'd5);
    chk("single_data", 32'(bus.vram_data), 32'h0241);
    tick();
    chk("single_we_drop", 32'(bus.vram_we), 32'd0);
    bus.videoflag = 1'b0;
    tick(); tick();
    chk("single_strobes", 32'(n_strobes),      32'd1);
    chk("single_cnt_end", 32'(bus.fifo_count), 32'd0);

    // Stall and overfill
    bus.vram_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back({16'(i), 16'h0100 + 16'(i)});
      req(16'(i), 16'h0100 + 16'(i));
    end
    chk("fill_count", 32'(bus.fifo_count), 32'd8);
    chk("fill_ovf",   32'(bus.overflow),   32'd1);
    bus.vram_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("burst_we", 32'(bus.vram_we), 32'd1);
    end
    tick();
    chk("burst_we_end",  32'(bus.vram_we),    32'd0);
    chk("burst_cnt_end", 32'(bus.fifo_count), 32'd0);

    // Error clear
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);

    // Refill, then overflow in the same cycle as err_clr
    bus.vram_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({16'd10 + 16'(i), 16'h0300 + 16'(i)});
      req(16'd10 + 16'(i), 16'h0300 + 16'(i));
    end
    chk("refill_count", 32'(bus.fifo_count), 32'd8);
    bus.videoflag = 1'b1; bus.bus_vga_pos = 16'd30; bus.bus_vga_char = 16'h0777;
    bus.err_clr = 1'b1;
    tick();
    bus.videoflag = 1'b0; bus.err_clr = 1'b0;
    chk("ovf_set_wins", 32'(bus.overflow), 32'd1);
    tick();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("ovf_cleared2", 32'(bus.overflow), 32'd0);

    // Push on full with a simultaneous pop
    bus.vram_ready = 1'b1;
    bus.videoflag = 1'b1; bus.bus_vga_pos = 16'd18; bus.bus_vga_char = 16'h0412;
    exp_q.push_back({16'd18, 16'h0412});
    tick();
    bus.videoflag = 1'b0;
    chk("fullpop_count", 32'(bus.fifo_count), 32'd8);
    chk("fullpop_ovf",   32'(bus.overflow),   32'd0);
    for (int i = 0; i < 9; i++) tick();
    chk("fullpop_drained", 32'(bus.fifo_count), 32'd0);
    chk("fullpop_ovf_end", 32'(bus.overflow),   32'd0);

    // Out-of-range and last valid position
    base = n_strobes;
    bus.videoflag = 1'b1; bus.bus_vga_pos = 16'd1200; bus.bus_vga_char = 16'h0555;
    tick();
    bus.videoflag = 1'b0;
    chk("oor_poserr", 32'(bus.pos_err),    32'd1);
    chk("oor_count",  32'(bus.fifo_count), 32'd0);
    tick(); tick(); tick();
    chk("oor_no_strobe", 32'(n_strobes), 32'(base));
    exp_q.push_back({16'd1199, 16'h0666});
    bus.videoflag = 1'b1; bus.bus_vga_pos = 16'd1199; bus.bus_vga_char = 16'h0666;
    tick();
    bus.videoflag = 1'b0;
    tick(); tick();
    chk("max_pos_strobe", 32'(n_strobes),   32'(base + 1));
    chk("poserr_sticky",  32'(bus.pos_err), 32'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("poserr_cleared", 32'(bus.pos_err), 32'd0);

    // Asynchronous reset while draining
    bus.vram_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({16'd20 + 16'(i), 16'h0500 + 16'(i)});
      req(16'd20 + 16'(i), 16'h0500 + 16'(i));
    end
    chk("pre_rst_count", 32'(bus.fifo_count), 32'd4);
    bus.vram_ready = 1'b1;
    tick();
    chk("pre_rst_we", 32'(bus.vram_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_we",    32'(bus.vram_we),    32'd0);
    chk("async_rst_count", 32'(bus.fifo_count), 32'd0);
    exp_q.delete();
    base = n_strobes;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("post_rst_no_strobe", 32'(n_strobes),      32'(base));
    chk("post_rst_count",     32'(bus.fifo_count), 32'd0);
    chk("sb_empty",           32'(exp_q.size()),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
